rtc_bus_responder: RTL and testbench

- Register-level responder for the multiplexed address/data RTC bus that the controller side drives using its RTC address map.
- Decodes address, write and read phases from externally driven strobes, and keeps an 11-entry register file at the controller's RTC addresses.
- Runs a BCD seconds/minutes/hours counter so the controller can be exercised in simulation and on the board without the physical RTC.

---
 rtl/rtc_bus_responder.sv | 197 +++++++++++++++++++
 tb/tb_rtc_bus_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_responder.sv
// Register-level responder for the multiplexed RTC address/data bus, with a
// free-running BCD seconds/minutes/hours counter behind the controller's RTC map.
module rtc_bus_responder #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       ad,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       addr_valid,
  output logic       tick
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned NREGS = 11;

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sr, ad_sr, wr_sr, rd_sr;
  logic cs_s, ad_s, wr_s, rd_s;
  logic cs_p, wr_p, rd_p;
  logic wr_fall, wr_rise, rd_fall, rd_rise, cs_rise;

  logic [7:0] addr_q;
  logic [4:0] dec_q, dec_in;
  logic [3:0] idx;
  logic       latch_addr, commit, load_rd;

  logic [7:0] regs [NREGS];
  logic       inc_pend, do_inc;
  logic [8:0] sec_n, min_n, hour_n;
  logic [DIV_W-1:0] div_q;

  // {hit, index} for an RTC address
  function automatic logic [4:0] decode(input logic [7:0] a);
    case (a)
      8'h00:   return 5'h10;
      8'h33:   return 5'h11;
      8'h34:   return 5'h12;
      8'h35:   return 5'h13;
      8'h36:   return 5'h14;
      8'h37:   return 5'h15;
      8'h38:   return 5'h16;
      8'h64:   return 5'h17;
      8'h65:   return 5'h18;
      8'h66:   return 5'h19;
      8'h67:   return 5'h1A;
      default: return 5'h00;
    endcase
  endfunction

  // {carry, next}: out-of-range digits roll forward, anything at/over the limit wraps
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v[7:4] > lim[7:4] || (v[7:4] == lim[7:4] && v[3:0] >= lim[3:0]))
      return {1'b1, 8'h00};
    if (v[3:0] >= 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'h0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign cs_s    = cs_sr[SYNC_STAGES-1];
  assign ad_s    = ad_sr[SYNC_STAGES-1];
  assign wr_s    = wr_sr[SYNC_STAGES-1];
  assign rd_s    = rd_sr[SYNC_STAGES-1];
  assign wr_fall = wr_p & ~wr_s;
  assign wr_rise = ~wr_p & wr_s;
  assign rd_fall = rd_p & ~rd_s;
  assign rd_rise = ~rd_p & rd_s;
  assign cs_rise = ~cs_p & cs_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sr <= '1;
      ad_sr <= '0;
      wr_sr <= '1;
      rd_sr <= '1;
      cs_p  <= 1'b1;
      wr_p  <= 1'b1;
      rd_p  <= 1'b1;
    end else begin
      cs_sr <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      ad_sr <= {ad_sr[SYNC_STAGES-2:0], ad};
      wr_sr <= {wr_sr[SYNC_STAGES-2:0], wr_n};
      rd_sr <= {rd_sr[SYNC_STAGES-2:0], rd_n};
      cs_p  <= cs_s;
      wr_p  <= wr_s;
      rd_p  <= rd_s;
    end
  end

  assign dec_in = decode(data_in);
  assign dec_q  = decode(addr_q);
  assign idx    = dec_q[3:0];

  always_comb begin
    state_d    = state_q;
    latch_addr = 1'b0;
    commit     = 1'b0;
    load_rd    = 1'b0;
    if (cs_rise || (!wr_s && !rd_s)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cs_s && wr_fall) begin
            state_d = ad_s ? ADDR : WRITE;
          end else if (!cs_s && !ad_s && rd_fall) begin
            state_d = READ;
            load_rd = 1'b1;
          end
        end
        ADDR: begin
          if (wr_rise) begin
            state_d    = IDLE;
            latch_addr = 1'b1;
          end
        end
        WRITE: begin
          if (wr_rise) begin
            state_d = IDLE;
            commit  = addr_valid;
          end
        end
        READ: begin
          if (rd_rise) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 8'h00;
      addr_valid <= 1'b0;
      data_out   <= 8'h00;
      data_oe    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_oe <= (state_d == READ);
      if (latch_addr) begin
        addr_q     <= data_in;
        addr_valid <= dec_in[4];
      end
      if (load_rd) data_out <= addr_valid ? regs[idx] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else if (div_q == DIV_W'(TICK_DIV - 1)) begin
      div_q <= '0;
      tick  <= 1'b1;
    end else begin
      div_q <= div_q + DIV_W'(1);
      tick  <= 1'b0;
    end
  end

  assign do_inc = (tick && regs[0][0]) || inc_pend;
  assign sec_n  = bcd_inc(regs[1], 8'h59);
  assign min_n  = bcd_inc(regs[2], 8'h59);
  assign hour_n = bcd_inc(regs[3], 8'h23);

  // A commit wins the cycle; a coincident increment is deferred one cycle and
  // then operates on the freshly written value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= (i == 0) ? 8'h01 : 8'h00;
      inc_pend <= 1'b0;
    end else if (commit) begin
      regs[idx] <= data_in;
      inc_pend  <= do_inc;
    end else begin
      inc_pend <= 1'b0;
      if (do_inc) begin
        regs[1] <= sec_n[7:0];
        if (sec_n[8]) begin
          regs[2] <= min_n[7:0];
          if (min_n[8]) regs[3] <= hour_n[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed + randomized bus transactions against a register/BCD reference model.
module tb_rtc_bus_responder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TDIV = 128;
  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       reset, cs_n, ad, wr_n, rd_n;
  logic [7:0] data_in, data_out;
  logic       data_oe, addr_valid, tick;
  logic [7:0] f_data_out;
  logic       f_data_oe, f_addr_valid, f_tick;

  int checks = 0;
  int errors = 0;

  logic [7:0] mregs [11];
  logic [7:0] vaddr [11];

  rtc_bus_responder #(.TICK_DIV(TDIV), .SYNC_STAGES(SYNC)) u_dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .ad(ad), .wr_n(wr_n), .rd_n(rd_n),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .addr_valid(addr_valid), .tick(tick)
  );

  rtc_bus_responder #(.TICK_DIV(4), .SYNC_STAGES(SYNC)) u_div4 (
    .clk(clk), .reset(reset), .cs_n(1'b1), .ad(1'b0), .wr_n(1'b1), .rd_n(1'b1),
    .data_in(8'h00), .data_out(f_data_out), .data_oe(f_data_oe),
    .addr_valid(f_addr_valid), .tick(f_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Next value of a BCD field with limit lim (59 or 23); bit 8 is the carry out.
  function automatic logic [8:0] model_inc(input logic [7:0] v, input int lim);
    int t, o, n;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (o <= 9 && t * 10 + o <= lim) begin
      n = t * 10 + o + 1;
      if (n > lim) return 9'h100;
      return {1'b0, to_bcd(n)};
    end
    if (t > lim / 10) return 9'h100;
    if (o > 9) begin
      if (t + 1 > lim / 10) return 9'h100;
      return {1'b0, 4'(t + 1), 4'h0};
    end
    return 9'h100;
  endfunction

  task automatic model_tick();
    logic [8:0] r;
    r = model_inc(mregs[1], 59);
    mregs[1] = r[7:0];
    if (r[8]) begin
      r = model_inc(mregs[2], 59);
      mregs[2] = r[7:0];
      if (r[8]) begin
        r = model_inc(mregs[3], 23);
        mregs[3] = r[7:0];
      end
    end
  endtask

  task automatic step();
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic bus_addr(input logic [7:0] a);
    cs_n = 1'b0; ad = 1'b1; data_in = a;
    step();
    wr_n = 1'b0;
    step();
    wr_n = 1'b1;
    step();
    cs_n = 1'b1; ad = 1'b0;
    step();
  endtask

  task automatic bus_write(input logic [7:0] d);
    cs_n = 1'b0; ad = 1'b0; data_in = d;
    step();
    wr_n = 1'b0;
    step();
    wr_n = 1'b1;
    step();
    cs_n = 1'b1;
    step();
  endtask

  task automatic bus_read(output logic [7:0] d, output logic oe, output int lat);
    cs_n = 1'b0; ad = 1'b0;
    step();
    rd_n = 1'b0;
    step();
    @(negedge clk);
    d  = data_out;
    oe = data_oe;
    @(posedge clk); #1;
    rd_n = 1'b1;
    lat = 0;
    while (data_oe && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    step();
    cs_n = 1'b1;
    step();
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       oe;
    int         lat;
    bus_addr(a);
    bus_read(d, oe, lat);
    check(tag, d, exp);
  endtask

  task automatic wait_tick();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 4 * TDIV; i++) begin
      @(negedge clk);
      if (tick) begin
        got = 1'b1;
        break;
      end
    end
    check("tick_seen", {7'd0, got}, 8'h01);
    @(posedge clk); #1;
  endtask

  // Run the time counter for exactly one tick; the address must already be CTRL.
  task automatic run_one_tick();
    wait_tick();
    bus_write(8'h01);
    wait_tick();
    bus_write(8'h00);
  endtask

  initial begin
    logic [7:0] d, v;
    logic       oe;
    int         lat, ri, wi;
    logic [7:0] tvals [8];
    logic       got;

    vaddr = '{8'h00, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h64, 8'h65, 8'h66, 8'h67};
    for (int i = 0; i < 11; i++) mregs[i] = 8'h00;
    mregs[0] = 8'h01;

    reset = 1'b0; cs_n = 1'b1; ad = 1'b0; wr_n = 1'b1; rd_n = 1'b1; data_in = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_oe", {7'd0, data_oe}, 8'h00);
    check("rst_addr_valid", {7'd0, addr_valid}, 8'h00);
    check("rst_tick", {7'd0, tick}, 8'h00);

    // SEC first, before the first tick can advance it
    bus_addr(8'h33);
    check("addr_valid_hit", {7'd0, addr_valid}, 8'h01);
    bus_read(d, oe, lat);
    check("rst_sec", d, 8'h00);
    read_check("rst_ctrl", 8'h00, 8'h01);

    bus_addr(8'h00);
    bus_write(8'h00);
    mregs[0] = 8'h00;
    for (int i = 1; i < 11; i++) begin
      if (i == 1 || i == 2) v = to_bcd(int'($urandom_range(0, 59)));
      else if (i == 3)      v = to_bcd(int'($urandom_range(0, 23)));
      else                  v = 8'($urandom);
      bus_addr(vaddr[i]);
      bus_write(v);
      mregs[i] = v;
    end

    bus_addr(8'h64);
    bus_write(8'hA5);
    mregs[7] = 8'hA5;
    bus_addr(8'h64);
    bus_read(d, oe, lat);
    check("scratch_a5", d, 8'hA5);
    check("read_oe_high", {7'd0, oe}, 8'h01);
    check("oe_fall_bound", {7'd0, lat <= int'(SYNC + 1)}, 8'h01);

    for (int k = 0; k < 6; k++) begin
      wi = int'($urandom_range(4, 10));
      v  = 8'($urandom);
      bus_addr(vaddr[wi]);
      bus_write(v);
      mregs[wi] = v;
      ri = int'($urandom_range(0, 10));
      read_check("rand_rw", vaddr[ri], mregs[ri]);
    end

    bus_addr(8'h50);
    check("addr_valid_miss", {7'd0, addr_valid}, 8'h00);
    bus_write(8'h77);
    bus_read(d, oe, lat);
    check("invalid_read", d, 8'h00);
    for (int i = 0; i < 11; i++) read_check("map_unchanged", vaddr[i], mregs[i]);

    bus_addr(8'h33); bus_write(8'h59); mregs[1] = 8'h59;
    bus_addr(8'h34); bus_write(8'h59); mregs[2] = 8'h59;
    bus_addr(8'h35); bus_write(8'h23); mregs[3] = 8'h23;
    bus_addr(8'h00);
    run_one_tick();
    model_tick();
    read_check("roll_sec", 8'h33, mregs[1]);
    read_check("roll_min", 8'h34, mregs[2]);
    read_check("roll_hour", 8'h35, mregs[3]);

    repeat (3) wait_tick();
    read_check("stopped_sec", 8'h33, mregs[1]);
    bus_addr(8'h00);
    run_one_tick();
    model_tick();
    read_check("resume_sec", 8'h33, mregs[1]);

    for (int k = 0; k < 4; k++) tvals[k] = to_bcd(int'($urandom_range(0, 59)));
    tvals[4] = 8'h1F; tvals[5] = 8'h5A; tvals[6] = 8'h73; tvals[7] = 8'h59;
    for (int k = 0; k < 8; k++) begin
      bus_addr(8'h33);
      bus_write(tvals[k]);
      mregs[1] = tvals[k];
      bus_addr(8'h00);
      run_one_tick();
      model_tick();
      read_check("bcd_sec", 8'h33, mregs[1]);
    end
    read_check("bcd_min", 8'h34, mregs[2]);
    read_check("bcd_hour", 8'h35, mregs[3]);

    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (f_tick) begin
        got = 1'b1;
        break;
      end
    end
    check("div4_tick_seen", {7'd0, got}, 8'h01);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("div4_tick_shape", {7'd0, f_tick}, {7'd0, (i % 4) == 0});
    end
    @(posedge clk); #1;

    bus_addr(8'h36);
    cs_n = 1'b0; ad = 1'b0; data_in = 8'h3C;
    step();
    wr_n = 1'b0; rd_n = 1'b0;
    step();
    @(negedge clk);
    check("proto_err_oe", {7'd0, data_oe}, 8'h00);
    @(posedge clk); #1;
    wr_n = 1'b1; rd_n = 1'b1;
    step();
    cs_n = 1'b1;
    step();
    read_check("proto_err_nocommit", 8'h36, mregs[4]);

    bus_addr(8'h37);
    cs_n = 1'b0; ad = 1'b0;
    step();
    rd_n = 1'b0;
    step();
    @(negedge clk);
    check("midread_oe", {7'd0, data_oe}, 8'h01);
    #2 reset = 1'b0;
    #1;
    check("async_rst_oe", {7'd0, data_oe}, 8'h00);
    check("async_rst_data", data_out, 8'h00);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 11; i++) mregs[i] = 8'h00;
    mregs[0] = 8'h01;
    step();
    check("post_rst_addr_valid", {7'd0, addr_valid}, 8'h00);
    read_check("post_rst_ctrl", 8'h00, mregs[0]);
    read_check("post_rst_scratch", 8'h37, mregs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
